// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// seven-segment display path.
//   state_t    : converter FSM states (IDLE, SHIFT)
//   CODE_BLANK : digit code the seven-segment decoder shows as blank
//   CODE_DASH  : digit code shown as a dash
//   CODE_OVF   : digit code filled into every digit when the result overflows
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_OVF   = 4'hE;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit greater than 4 gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   digit : current 4-bit scratch digit
//   adj   : corrected digit (4-bit result, no carry out)
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    always_comb begin
        adj = digit;
        if (digit > 4'd4) begin
            adj = digit + 4'd3;
        end
    end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle double-dabble converter: DATA_W-bit binary (optionally two's
// complement) operand to DIGITS packed BCD digits, one shift per clock.
//   clock, reset_n : system clock, asynchronous active-low reset
//   start          : conversion request, sampled only while idle
//   bin_in         : operand, captured on the accepting edge
//   signed_mode    : operand is two's complement (ignored when SIGNED_EN=0)
//   busy           : conversion in progress (exactly DATA_W cycles)
//   done           : one-cycle pulse, results valid from this cycle
//   bcd_out        : packed digits, LSD in [3:0]; held between conversions
//   negative       : sign of the last converted operand
//   overflow       : last operand did not fit in DIGITS digits
//   state_dbg      : current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// converter is idle (busy=0, which includes the done cycle). start while busy
// is dropped, not queued. done pulses for one cycle at completion and the
// result outputs change only on that edge.
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIGITS    = 10,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative,
    output logic                  overflow,
    output logic                  state_dbg
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] mag;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     adj;
    logic              sign;
    logic              ovf_sticky;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              last_iter;
    logic              neg_in;
    logic              ovf_final;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == SHIFT) && (cnt == CW'(DATA_W - 1));
    assign neg_in    = SIGNED_EN && signed_mode && bin_in[DATA_W-1];
    // The bit leaving the scratch MSB on this shift also counts as overflow.
    assign ovf_final = ovf_sticky | adj[SW-1];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit (scratch[4*g +: 4]),
                .adj   (adj[4*g +: 4])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start)     state_n = SHIFT;
            SHIFT:   if (last_iter) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state == SHIFT);
        state_dbg = (state == SHIFT);
    end

    // Datapath: operand capture, shift iterations and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag        <= '0;
            scratch    <= '0;
            sign       <= 1'b0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            done       <= 1'b0;
            bcd_out    <= '0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= last_iter;
            if (accept) begin
                // Most-negative operand negates to itself, which is the
                // correct unsigned magnitude 2^(DATA_W-1).
                mag        <= neg_in ? (~bin_in + DATA_W'(1)) : bin_in;
                sign       <= neg_in;
                scratch    <= '0;
                ovf_sticky <= 1'b0;
                cnt        <= '0;
            end else if (state == SHIFT) begin
                scratch    <= {adj[SW-2:0], mag[DATA_W-1]};
                mag        <= {mag[DATA_W-2:0], 1'b0};
                ovf_sticky <= ovf_final;
                cnt        <= cnt + CW'(1);
                if (last_iter) begin
                    bcd_out  <= ovf_final ? {DIGITS{CODE_OVF}}
                                          : {adj[SW-2:0], mag[DATA_W-1]};
                    negative <= sign;
                    overflow <= ovf_final;
                end
            end
        end
    end

endmodule
